// File: rtl/mem_bus_if_pkg.sv
// Shared types for the data-memory bus front end: FSM state encoding and access sizes.
package mem_bus_if_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        DROP = 3'd4
    } busState_t;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

    // States in which a transaction is waiting on the bus and the watchdog runs.
    function automatic logic isBusBusy(input busState_t s);
        return (s == REQ) || (s == WAIT);
    endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Cycle counter for REQ/WAIT residency; raises hit on the TIMEOUT_CYCLES-th cycle.
module mem_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic inReq,
    input  logic inWait,
    output logic hit
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntEff;
    logic             prevReq;
    logic             prevWait;
    logic             active;
    logic             entry;

    // A fresh entry into REQ or WAIT restarts the count in that same cycle.
    assign active = inReq | inWait;
    assign entry  = (inReq & ~prevReq) | (inWait & ~prevWait);
    assign cntEff = entry ? '0 : cnt;
    assign hit    = active && (cntEff == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            prevReq  <= 1'b0;
            prevWait <= 1'b0;
        end else begin
            prevReq  <= inReq;
            prevWait <= inWait;
            if (active && (cntEff != LAST)) begin
                cnt <= cntEff + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_bus_if.sv
// MEM-stage data bus front end: issues one SRAM-like transaction per access, captures load data
// into RAMtmp and stalls the pipeline until done. Optional watchdog under MEM_BUS_TIMEOUT_EN.
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemValidM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        MemReadType,
    input  logic [ADDR_W-1:0] ALUout,
    input  logic [STRB_W-1:0] calWE,
    input  logic [DATA_W-1:0] StoreData,
    input  logic              ext_stall,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [SIZE_W-1:0] data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [STRB_W-1:0] data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] RAMtmp,
    output logic              mem_stall,
    output logic              bus_err
);

    busState_t state;
    logic      acc;
    logic      issue;
    logic      isWrite;
    logic      tmo;
    logic      unusedSizeHi;

    assign acc          = MemValidM & (MemReadM | MemWriteM);
    assign issue        = acc & ~flush;
    assign unusedSizeHi = MemReadType[2];

`ifdef MEM_BUS_TIMEOUT_EN
    logic wdHit;

    mem_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .inReq (state == REQ),
        .inWait(state == WAIT),
        .hit   (wdHit)
    );

    // A response arriving on the deadline cycle completes normally instead of timing out.
    assign tmo     = wdHit & isBusBusy(state) & ~((state == WAIT) & data_data_ok);
    assign bus_err = tmo;
`else
    localparam int unsigned unusedTimeout = TIMEOUT_CYCLES;

    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Bus payload follows the MEM-stage operands, which the stall holds steady.
    assign data_wr    = MemWriteM;
    assign data_size  = MemReadType[1:0];
    assign data_addr  = ALUout;
    assign data_wstrb = MemWriteM ? calWE : '0;
    assign data_wdata = StoreData;

    always_comb begin
        data_req  = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                data_req  = issue;
                mem_stall = issue;
            end
            REQ: begin
                data_req  = 1'b1;
                mem_stall = 1'b1;
            end
            WAIT, DROP: mem_stall = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            RAMtmp  <= '0;
            isWrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        isWrite <= MemWriteM;
                        state   <= data_addr_ok ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (tmo) begin
                        RAMtmp <= '0;
                        state  <= data_addr_ok ? DROP : DONE;
                    end else if (data_addr_ok) begin
                        state <= flush ? DROP : WAIT;
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            state <= DONE;
                            if (!isWrite) begin
                                RAMtmp <= data_rdata;
                            end
                        end
                    end else if (tmo) begin
                        RAMtmp <= '0;
                        state  <= DROP;
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                // Hold off re-issue until the pipeline actually moves past this instruction.
                DONE: begin
                    if (flush || !ext_stall) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (data_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Scoreboard bench for mem_bus_if: expected RAMtmp values queued at issue, checked at completion.
`timescale 1ns/1ps
module tb_mem_bus_if;
    import mem_bus_if_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TMO    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              MemValidM, MemReadM, MemWriteM;
    logic [2:0]        MemReadType;
    logic [ADDR_W-1:0] ALUout;
    logic [3:0]        calWE;
    logic [31:0]       StoreData;
    logic              ext_stall, flush;
    logic              data_req, data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok, data_data_ok;
    logic [31:0]       data_rdata;
    logic [31:0]       RAMtmp;
    logic              mem_stall, bus_err;

    int          checks   = 0;
    int          errors   = 0;
    int          txnCount = 0;
    logic [31:0] expQ[$];
    logic [31:0] ramModel = 32'h0;

    always #5 clk = ~clk;

    mem_bus_if #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .MemValidM(MemValidM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .MemReadType(MemReadType), .ALUout(ALUout), .calWE(calWE), .StoreData(StoreData),
        .ext_stall(ext_stall), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .RAMtmp(RAMtmp), .mem_stall(mem_stall), .bus_err(bus_err)
    );

    // Accepted address handshakes, i.e. bus transactions started.
    always @(negedge clk) if (rst && data_req && data_addr_ok) txnCount++;

    // A response may only arrive while a transaction is outstanding (WAIT or DROP).
    property pNoStrayDataOk;
        @(posedge clk) disable iff (!rst) data_data_ok |-> (mem_stall && !data_req);
    endproperty
    assert property (pNoStrayDataOk) else $error("FAIL proto data_ok seen outside WAIT/DROP");

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInstr();
        MemValidM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        flush = 1'b0; ext_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    endtask

    task automatic setLoad(input logic [31:0] addr);
        MemValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0;
        MemReadType = 3'b010; ALUout = addr; calWE = 4'b1111; StoreData = 32'h5555_AAAA;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0 || mem_stall !== 1'b0 || RAMtmp !== 32'h0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset req=%b stall=%b ram=%h err=%b, expected 0 0 00000000 0",
                     data_req, mem_stall, RAMtmp, bus_err);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_word_load();
        logic [31:0] exp;
        int stallCycles = 0;
        ramModel = 32'hDEADBEEF;
        expQ.push_back(ramModel);
        setLoad(32'h8000_1000);
        data_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b1 || data_size !== SZ_WORD || data_wstrb !== 4'b0000 ||
            data_addr !== 32'h8000_1000 || data_wr !== 1'b0) begin
            errors++;
            $display("FAIL load_issue req=%b size=%b wstrb=%b addr=%h wr=%b, expected 1 10 0000 80001000 0",
                     data_req, data_size, data_wstrb, data_addr, data_wr);
        end
        if (mem_stall) stallCycles++;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0) begin
            errors++;
            $display("FAIL load_wait_req req=%b, expected 0", data_req);
        end
        if (mem_stall) stallCycles++;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        @(negedge clk);
        if (mem_stall) stallCycles++;
        exp = expQ.pop_front();
        checks++;
        if (RAMtmp !== exp) begin
            errors++;
            $display("FAIL load_data RAMtmp=%h, expected %h", RAMtmp, exp);
        end
        checks++;
        if (stallCycles != 2) begin
            errors++;
            $display("FAIL load_latency stall_cycles=%0d, expected 2", stallCycles);
        end
        tick();
        clearInstr();
    endtask

    task automatic test_byte_store();
        logic [31:0] exp;
        int reqCycles = 0;
        int badPayload = 0;
        int txn0 = txnCount;
        expQ.push_back(ramModel);
        MemValidM = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b1; MemReadType = 3'b000;
        ALUout = 32'h8000_1001; calWE = 4'b0100; StoreData = 32'h00AB_0000;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            @(negedge clk);
            if (data_req) reqCycles++;
            if (data_wr !== 1'b1 || data_wstrb !== 4'b0100 || data_size !== SZ_BYTE ||
                data_wdata !== 32'h00AB_0000 || data_addr !== 32'h8000_1001 || mem_stall !== 1'b1)
                badPayload++;
            tick();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (badPayload != 0) begin
            errors++;
            $display("FAIL store_payload bad_cycles=%0d, expected 0", badPayload);
        end
        checks++;
        if (reqCycles != 4) begin
            errors++;
            $display("FAIL store_req_len req_cycles=%0d, expected 4", reqCycles);
        end
        exp = expQ.pop_front();
        checks++;
        if (mem_stall !== 1'b0 || RAMtmp !== exp || txnCount - txn0 != 1) begin
            errors++;
            $display("FAIL store_done stall=%b RAMtmp=%h txns=%0d, expected 0 %h 1",
                     mem_stall, RAMtmp, txnCount - txn0, exp);
        end
        tick();
        clearInstr();
    endtask

    task automatic test_ext_stall();
        logic [31:0] exp;
        int reqCycles = 0;
        int badDone = 0;
        int txn0 = txnCount;
        ramModel = 32'hCAFE_F00D;
        expQ.push_back(ramModel);
        setLoad(32'h8000_2000);
        data_addr_ok = 1'b1;
        @(negedge clk);
        if (data_req) reqCycles++;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; ext_stall = 1'b1;
        @(negedge clk);
        if (data_req) reqCycles++;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        exp = expQ.pop_front();
        for (int i = 0; i < 3; i++) begin
            ext_stall = (i < 2);
            @(negedge clk);
            if (data_req) reqCycles++;
            if (mem_stall !== 1'b0 || RAMtmp !== exp) badDone++;
            tick();
        end
        clearInstr();
        @(negedge clk);
        checks++;
        if (badDone != 0) begin
            errors++;
            $display("FAIL ext_stall_hold bad_cycles=%0d, expected 0 (RAMtmp=%h exp=%h)", badDone, RAMtmp, exp);
        end
        checks++;
        if (reqCycles != 1 || txnCount - txn0 != 1) begin
            errors++;
            $display("FAIL ext_stall_reissue req_cycles=%0d txns=%0d, expected 1 1", reqCycles, txnCount - txn0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int txn0 = txnCount;
        logic [31:0] words[2];
        words[0] = 32'h1111_2222;
        words[1] = 32'h3333_4444;
        for (int k = 0; k < 2; k++) expQ.push_back(words[k]);
        ramModel = words[1];
        for (int k = 0; k < 2; k++) begin
            setLoad(32'h8000_3000 + 32'(k * 4));
            data_addr_ok = 1'b1;
            tick();
            data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = words[k];
            tick();
            data_data_ok = 1'b0; data_rdata = '0;
            @(negedge clk);
            exp = expQ.pop_front();
            checks++;
            if (RAMtmp !== exp || mem_stall !== 1'b0 || data_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d RAMtmp=%h stall=%b req=%b, expected %h 0 0",
                         k, RAMtmp, mem_stall, data_req, exp);
            end
            tick();
        end
        clearInstr();
        checks++;
        if (txnCount - txn0 != 2) begin
            errors++;
            $display("FAIL b2b_txns txns=%0d, expected 2", txnCount - txn0);
        end
    endtask

    task automatic test_flush_wait();
        logic [31:0] exp;
        int stallBad = 0;
        expQ.push_back(ramModel);
        setLoad(32'h8000_4000);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        if (mem_stall !== 1'b1) stallBad++;
        tick();
        flush = 1'b0; MemValidM = 1'b0; MemReadM = 1'b0;
        @(negedge clk);
        if (mem_stall !== 1'b1 || data_req !== 1'b0) stallBad++;
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        @(negedge clk);
        if (mem_stall !== 1'b1) stallBad++;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        @(negedge clk);
        checks++;
        if (stallBad != 0) begin
            errors++;
            $display("FAIL flush_wait_stall bad_cycles=%0d, expected 0", stallBad);
        end
        exp = expQ.pop_front();
        checks++;
        if (mem_stall !== 1'b0 || RAMtmp !== exp) begin
            errors++;
            $display("FAIL flush_wait_drop stall=%b RAMtmp=%h, expected 0 %h", mem_stall, RAMtmp, exp);
        end
        tick();
        clearInstr();
    endtask

    task automatic test_flush_req();
        int txn0 = txnCount;
        setLoad(32'h8000_5000);
        tick();
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_req_hold req=%b, expected 1", data_req);
        end
        tick();
        clearInstr();
        @(negedge clk);
        checks++;
        if (data_req !== 1'b0 || mem_stall !== 1'b0 || txnCount != txn0) begin
            errors++;
            $display("FAIL flush_req_withdraw req=%b stall=%b txns=%0d, expected 0 0 0",
                     data_req, mem_stall, txnCount - txn0);
        end
        tick();
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int errCycle = -1;
        setLoad(32'h8000_6000);
        tick();
        for (int i = 1; i <= 20 && errCycle < 0; i++) begin
            @(negedge clk);
            if (bus_err) errCycle = i;
            else tick();
        end
        checks++;
        if (errCycle != int'(TMO)) begin
            errors++;
            $display("FAIL timeout_cycle bus_err_cycle=%0d, expected %0d", errCycle, TMO);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || RAMtmp !== 32'h0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done stall=%b RAMtmp=%h err=%b, expected 0 00000000 0",
                     mem_stall, RAMtmp, bus_err);
        end
        tick();
        clearInstr();
        ramModel = 32'h0;
    endtask
`else
    task automatic test_timeout();
        int bad = 0;
        setLoad(32'h8000_6000);
        tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_err !== 1'b0 || mem_stall !== 1'b1 || data_req !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_timeout_wait bad_cycles=%0d, expected 0", bad);
        end
        flush = 1'b1;
        tick();
        clearInstr();
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || RAMtmp !== ramModel) begin
            errors++;
            $display("FAIL no_timeout_flush stall=%b RAMtmp=%h, expected 0 %h", mem_stall, RAMtmp, ramModel);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        setLoad(32'h8000_7000);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        MemValidM = 1'b0; MemReadM = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_stall !== 1'b0 || data_req !== 1'b0 || RAMtmp !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid stall=%b req=%b RAMtmp=%h, expected 0 0 00000000",
                     mem_stall, data_req, RAMtmp);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit reached without finishing");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        MemReadType = 3'b000; ALUout = '0; calWE = '0; StoreData = '0;
        clearInstr();
        test_reset();
        test_word_load();
        test_byte_store();
        test_ext_stall();
        test_back_to_back();
        test_flush_wait();
        test_flush_req();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
